queue_fifo: RTL

QUEUE_FIFO -- requirements
Module: queue_fifo

---
 rtl/queue_pkg.sv | 18 +
 rtl/queue_ram.sv | 56 +++++
 rtl/queue_fifo.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/queue_pkg.sv
// ---------------------------------------------------------------------------
// queue_pkg
// Shared constants and helpers for the queue_fifo block.
//   DEFAULT_DATA_WIDTH : default entry width in bits
//   DEFAULT_DEPTH      : default number of entries (power of two)
//   ptr_width()        : address width needed to index a queue of given depth
// ---------------------------------------------------------------------------
package queue_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_DEPTH      = 1024;

  // Address width of the storage array; pointers carry one extra wrap bit.
  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage : queue_pkg

// File: rtl/queue_ram.sv
// ---------------------------------------------------------------------------
// queue_ram
// Simple dual-port storage for queue_fifo: one write port, one read port,
// registered read, no reset on the array (maps onto block RAM).
// Ports:
//   i_clk    : clock, rising edge
//   i_reset  : synchronous active-high reset of the read-data register only
//   i_we     : write enable
//   i_waddr  : write address
//   i_wdata  : write data
//   i_re     : read enable; o_rdata updates only when set
//   i_raddr  : read address
//   o_rdata  : registered read data (read-before-write on address collision)
// ---------------------------------------------------------------------------
module queue_ram
  import queue_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int AW         = ptr_width(DEFAULT_DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_we,
  input  logic [AW-1:0]         i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [AW-1:0]         i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] mem [2**AW];
  logic [DATA_WIDTH-1:0] rdata_q;

  // NOTE: the array has no reset branch; a reset loop over every entry
  // would stop it mapping onto block RAM, and stale contents are never
  // observable because the pointers gate every read.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem[i_waddr] <= i_wdata;
    end
  end

  // NOTE: non-blocking assignments give read-before-write when a full queue
  // pushes and pops the same slot in one cycle, so the oldest entry is
  // returned rather than the one being written.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rdata_q <= '0;
    end else if (i_re) begin
      rdata_q <= mem[i_raddr];
    end
  end

  assign o_rdata = rdata_q;

endmodule : queue_ram

// File: rtl/queue_fifo.sv
// ---------------------------------------------------------------------------
// queue_fifo
// Single-clock FIFO queue with registered flags, sticky error flags and
// synchronous flush. Storage is the queue_ram sub-module.
// Optional feature: define QUEUE_FIFO_LEVEL_EN to add the o_level port and
// its occupancy counter.
// Ports:
//   i_master_clk      : clock, rising edge
//   i_reset           : synchronous active-high reset, highest priority
//   i_flush           : empty the queue, keep error flags, cancel requests
//   i_write_data      : entry to push
//   i_write_request   : push request
//   o_write_done      : push accepted (one cycle after the request)
//   i_read_request    : pop request
//   o_read_data       : last popped entry, changes only on an accepted pop
//   o_read_data_valid : o_read_data was popped by last cycle's request
//   o_empty / o_full  : registered occupancy flags
//   o_overflow        : sticky, set by a rejected push
//   o_underflow       : sticky, set by a rejected pop
//   o_level           : occupancy 0..DEPTH (QUEUE_FIFO_LEVEL_EN only)
// ---------------------------------------------------------------------------
module queue_fifo
  import queue_pkg::*;
#(
  parameter  int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter  int DEPTH      = DEFAULT_DEPTH,
  localparam int AW         = ptr_width(DEPTH)
) (
  input  logic                  i_master_clk,
  input  logic                  i_reset,
  input  logic                  i_flush,
  input  logic [DATA_WIDTH-1:0] i_write_data,
  input  logic                  i_write_request,
  output logic                  o_write_done,
  input  logic                  i_read_request,
  output logic [DATA_WIDTH-1:0] o_read_data,
  output logic                  o_read_data_valid,
  output logic                  o_empty,
  output logic                  o_full,
  output logic                  o_overflow,
  output logic                  o_underflow
`ifdef QUEUE_FIFO_LEVEL_EN
  ,
  output logic [AW:0]           o_level
`endif
);

  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        empty_q, empty_d;
  logic        full_q, full_d;
  logic        write_done_q, read_valid_q;
  logic        overflow_q, underflow_q;
  logic        push_acc, pop_acc;

  // A flush or reset cancels both requests outright. A push to a full queue
  // still goes through when a pop frees a slot in the same cycle.
  // NOTE: every always_comb output gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    pop_acc  = i_read_request && !empty_q && !i_flush && !i_reset;
    push_acc = i_write_request && (!full_q || pop_acc) && !i_flush && !i_reset;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop_acc)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    // The extra MSB separates "same slot, empty" from "same slot, wrapped".
    empty_d = (wr_ptr_d == rd_ptr_d);
    full_d  = (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]) && (wr_ptr_d[AW] != rd_ptr_d[AW]);
  end

  always_ff @(posedge i_master_clk) begin
    if (i_reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      empty_q      <= 1'b1;
      full_q       <= 1'b0;
      write_done_q <= 1'b0;
      read_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      empty_q      <= empty_d;
      full_q       <= full_d;
      write_done_q <= push_acc;
      read_valid_q <= pop_acc;
      // Requests cancelled by a flush are not errors.
      if (i_write_request && !push_acc && !i_flush) overflow_q  <= 1'b1;
      if (i_read_request  && !pop_acc  && !i_flush) underflow_q <= 1'b1;
    end
  end

  queue_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .AW         (AW)
  ) u_ram (
    .i_clk   (i_master_clk),
    .i_reset (i_reset),
    .i_we    (push_acc),
    .i_waddr (wr_ptr_q[AW-1:0]),
    .i_wdata (i_write_data),
    .i_re    (pop_acc),
    .i_raddr (rd_ptr_q[AW-1:0]),
    .o_rdata (o_read_data)
  );

`ifdef QUEUE_FIFO_LEVEL_EN
  logic [AW:0] level_q, level_d;

  always_comb begin
    level_d = level_q;
    if (i_flush) begin
      level_d = '0;
    end else if (push_acc && !pop_acc) begin
      level_d = level_q + PTR_ONE;
    end else if (pop_acc && !push_acc) begin
      level_d = level_q - PTR_ONE;
    end
  end

  always_ff @(posedge i_master_clk) begin
    if (i_reset) level_q <= '0;
    else         level_q <= level_d;
  end

  assign o_level = level_q;
`endif

  assign o_write_done      = write_done_q;
  assign o_read_data_valid = read_valid_q;
  assign o_empty           = empty_q;
  assign o_full            = full_q;
  assign o_overflow        = overflow_q;
  assign o_underflow       = underflow_q;

endmodule : queue_fifo
